decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
- Sequencer that drives the address and enable inputs of the 3-to-8 decoder stage directly downstream.
- Sweeps the 3-bit address across eight outputs. Each address is held enabled for a programmable dwell time, followed by a programmable blanking gap with enable low, so two decoder outputs are never active together.
- Supports single-sweep and continuous modes, a per-address skip mask, and abort.

Parameters:
- DWELL, 4, cycles `en` stays high per address; legal range 1 to 2^CW-1.
- BLANK, 1, cycles `en` stays low after each address; 0 means no gap; maximum 2^CW-1.
- CW, 8, width of the internal dwell/blank counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- stop  input  1  abort the sweep; has priority over start.
- cont  input  1  1 = restart automatically at the end of a sweep; sampled at the end of each sweep.
- mask  input  8  bit i = 1 skips address i; captured at sweep start.
- a  output  3  decoder address; registered.
- en  output  1  decoder enable; registered.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at the end of each completed sweep.

Behaviour:
- Reset (async, rst_n=0): a=0, en=0, busy=0, done=0, state=IDLE, counter=0, mask register=0. Outputs change immediately, without waiting for a clock edge.
- States: IDLE, ACTIVE (en=1), BLANK (en=0). All outputs are registered.
- IDLE: en=0, busy=0, a=0.
  - If start=1, stop=0 and mask!=8'hFF at edge t0: capture mask, then enter ACTIVE from cycle t0+1 with a = lowest unmasked index and busy=1.
  - If mask==8'hFF: start is ignored and the block stays in IDLE.
- ACTIVE: en=1 for exactly DWELL cycles.
  - If BLANK>0, go to BLANK: a held, en=0 for exactly BLANK cycles.
  - If BLANK=0, advance straight to the next address; en stays 1 and only a changes.
- Advance rule: next address is the next higher unmasked index.
- End of sweep: reached when no higher unmasked index exists after the last address's dwell+blank. In the following cycle:
  - done=1 for one cycle.
  - If cont=1: recapture mask. If the new mask is not all ones, enter ACTIVE at its lowest unmasked index in that same cycle; busy stays 1. If it is all ones, go to IDLE.
  - If cont=0: go to IDLE; busy=0 and a=0 in that cycle.
- Timing for address step k of a sweep, with S = DWELL+BLANK:
  - en=1 in cycles t0+1+kS .. t0+kS+DWELL.
  - Blank in cycles t0+kS+DWELL+1 .. t0+(k+1)S.
- a never changes while en=1, except at the dwell-to-dwell boundary when BLANK=0.
- stop=1 at any edge outside IDLE: next cycle IDLE, en=0, busy=0, a=0, done=0. The sweep is abandoned and done does not pulse.
- start while busy: ignored.
- Simultaneous start and stop in IDLE: stop wins; the block stays in IDLE.
- mask changes during a sweep: ignored until the next capture point (sweep start or continuous wrap).
- Counter: counts down from DWELL-1 or BLANK-1 in CW bits. DWELL=0 is illegal; implementation behaviour for it is undefined, and a simulation assertion flags it.

Test Plan:
1. DWELL=4, BLANK=1, mask=00, cont=0, 1-cycle start at t0 -> a=k with en=1 in cycles t0+1+5k..t0+4+5k and en=0 at t0+5+5k, for k=0..7. At t0+41: done=1, busy=0, a=0. At t0+42: done=0.
2. mask=8'hAA, same config -> only addresses 0, 2, 4, 6 enabled, 5 cycles per step. At t0+21: done=1 and busy=0. Addresses 1, 3, 5, 7 never appear with en=1.
3. cont=1, mask=00 -> at t0+41: done=1 together with a=0, en=1, busy=1. Drop cont during the second sweep -> the second sweep ends with done at t0+81, then IDLE.
4. stop pulsed at t0+12 (address 2 dwell) -> at t0+13: en=0, busy=0, a=0. done stays 0. A start pulse 2 cycles later restarts from the lowest unmasked address.
5. start with mask=8'hFF -> busy, en and done stay 0. Start pulses during an active sweep leave the timing of test 1 unchanged.
6. Instance DWELL=1, BLANK=0 -> en held high continuously for 8 cycles while a steps 0,1,...,7, one step per cycle. rst_n=0 mid-sweep without a clock edge -> en=0, a=0, busy=0 immediately.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// Scans a 3-to-8 decoder: each unmasked address is enabled for DWELL cycles, then blanked for BLANK cycles.
// Single-sweep or continuous operation, per-address skip mask, abort via stop.
module decoder_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int BLANK = 1,
   parameter int CW    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       cont,
   input  logic [7:0] mask,
   output logic [2:0] a,
   output logic       en,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    mask_q, mask_d;
   logic [2:0]    a_q, a_d;
   logic          en_q, en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          nxt_vld;
   logic [2:0]    nxt_idx;
   logic [2:0]    first_idx;
   logic          step_end;

   // Next higher unmasked address within the captured mask
   always_comb begin
      nxt_vld = 1'b0;
      nxt_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (i > int'(a_q) && !mask_q[i]) begin
            nxt_vld = 1'b1;
            nxt_idx = 3'(i);
         end
      end
   end

   // Lowest unmasked address of the live mask, used at every capture point
   always_comb begin
      first_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!mask[i]) begin
            first_idx = 3'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      a_d      = a_q;
      en_d     = en_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      step_end = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !stop && mask != 8'hFF) begin
               state_d = S_ACTIVE;
               mask_d  = mask;
               a_d     = first_idx;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = DWELL_LD;
            end
         end
         S_ACTIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (BLANK > 0) begin
               state_d = S_BLANK;
               en_d    = 1'b0;
               cnt_d   = BLANK_LD;
            end else begin
               step_end = 1'b1;
            end
         end
         S_BLANK: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               step_end = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (step_end) begin
         if (nxt_vld) begin
            state_d = S_ACTIVE;
            a_d     = nxt_idx;
            en_d    = 1'b1;
            cnt_d   = DWELL_LD;
         end else begin
            done_d = 1'b1;
            if (cont) begin
               mask_d = mask;
            end
            if (cont && mask != 8'hFF) begin
               state_d = S_ACTIVE;
               a_d     = first_idx;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = DWELL_LD;
            end else begin
               state_d = S_IDLE;
               a_d     = 3'd0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
      end

      // Abort wins over everything, including a pending done
      if (stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         a_d     = 3'd0;
         en_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mask_q  <= 8'h00;
         a_q     <= 3'd0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         a_q     <= a_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign a    = a_q;
   assign en   = en_q;
   assign busy = busy_q;
   assign done = done_q;

   a_dwell_nonzero: assert property (@(posedge clk) disable iff (!rst_n) DWELL != 0)
      else $error("decoder_scan_ctrl: DWELL must be at least 1");

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: per-cycle expectations derived from sweep timing are queued, then popped and checked.
module tb_decoder_scan_ctrl;

   typedef struct packed {
      logic [2:0] a;
      logic       en;
      logic       busy;
      logic       done;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n, rst6_n;
   logic       start, stop, cont;
   logic [7:0] mask;
   logic       start6, stop6, cont6;
   logic [7:0] mask6;
   logic [2:0] a, a6;
   logic       en, busy, done, en6, busy6, done6;
   logic       sel;
   obs_t       obs;
   obs_t       exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   decoder_scan_ctrl #(.DWELL(4), .BLANK(1), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont), .mask(mask),
      .a(a), .en(en), .busy(busy), .done(done)
   );

   decoder_scan_ctrl #(.DWELL(1), .BLANK(0), .CW(8)) dut6 (
      .clk(clk), .rst_n(rst6_n), .start(start6), .stop(stop6), .cont(cont6), .mask(mask6),
      .a(a6), .en(en6), .busy(busy6), .done(done6)
   );

   assign obs = sel ? obs_t'({a6, en6, busy6, done6}) : obs_t'({a, en, busy, done});

   task automatic push_n(input int n, input logic [2:0] pa, input logic pen,
                         input logic pbusy, input logic pdone);
      for (int i = 0; i < n; i++) exp_q.push_back(obs_t'({pa, pen, pbusy, pdone}));
   endtask

   // One sweep from the spec timing: dwell cycles with en=1, blank cycles with en=0, per unmasked address
   task automatic push_sweep(input logic [7:0] m, input int dw, input int bl, input bit first_done);
      bit first = 1'b1;
      for (int ad = 0; ad < 8; ad++) begin
         if (!m[ad]) begin
            for (int c = 0; c < dw; c++) begin
               exp_q.push_back(obs_t'({3'(ad), 1'b1, 1'b1, first & first_done}));
               first = 1'b0;
            end
            push_n(bl, 3'(ad), 1'b0, 1'b1, 1'b0);
         end
      end
   endtask

   task automatic check_now(input obs_t e, input string tag);
      n_cmp++;
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s: got a=%0d en=%b busy=%b done=%b, exp a=%0d en=%b busy=%b done=%b",
                tag, obs.a, obs.en, obs.busy, obs.done, e.a, e.en, e.busy, e.done);
      end
   endtask

   task automatic check_cycles(input int n, input string tag);
      obs_t e;
      for (int j = 0; j < n; j++) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: scoreboard empty, got a=%0d en=%b, exp an entry", tag, obs.a, obs.en);
         end else begin
            e = exp_q.pop_front();
            check_now(e, tag);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench at the observation point of cycle t0+1
   task automatic start_pulse(input bit which);
      @(negedge clk);
      if (which) start6 = 1'b1; else start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      start6 = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      start = 0; stop = 0; cont = 0; mask = 8'h00;
      start6 = 0; stop6 = 0; cont6 = 0; mask6 = 8'h00;
      rst_n = 1'b0;
      rst6_n = 1'b0;
      #2;
      check_now(obs_t'(6'b0), "reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_now(obs_t'(6'b0), "reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      rst6_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: full sweep, single shot
      start_pulse(0);
      push_sweep(8'h00, 4, 1, 0);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(42, "t1_sweep");

      // 2: mask AA, with a mask change mid-sweep that must be ignored
      mask = 8'hAA;
      start_pulse(0);
      push_sweep(8'hAA, 4, 1, 0);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(5, "t2_mask");
      mask = 8'h00;
      check_cycles(17, "t2_mask");

      // 3: continuous, drop cont during the second sweep
      cont = 1'b1;
      start_pulse(0);
      push_sweep(8'h00, 4, 1, 0);
      push_sweep(8'h00, 4, 1, 1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(45, "t3_cont");
      cont = 1'b0;
      check_cycles(37, "t3_cont");

      // 4: abort during address 2 dwell, then restart with a new mask
      start_pulse(0);
      push_n(4, 3'd0, 1'b1, 1'b1, 1'b0);
      push_n(1, 3'd0, 1'b0, 1'b1, 1'b0);
      push_n(4, 3'd1, 1'b1, 1'b1, 1'b0);
      push_n(1, 3'd1, 1'b0, 1'b1, 1'b0);
      push_n(2, 3'd2, 1'b1, 1'b1, 1'b0);
      push_n(2, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(11, "t4_pre_stop");
      stop = 1'b1;
      check_cycles(1, "t4_pre_stop");
      stop = 1'b0;
      check_cycles(2, "t4_abort");
      mask = 8'h05;
      start_pulse(0);
      push_sweep(8'h05, 4, 1, 0);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(32, "t4_restart");

      // 5: all-masked start, start+stop together, start held during a sweep
      mask = 8'hFF;
      start_pulse(0);
      push_n(5, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(5, "t5_all_masked");
      mask = 8'h00;
      @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      push_n(3, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(3, "t5_stop_wins");
      start_pulse(0);
      push_sweep(8'h00, 4, 1, 0);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(10, "t5_start_busy");
      start = 1'b1;
      check_cycles(10, "t5_start_busy");
      start = 1'b0;
      check_cycles(22, "t5_start_busy");

      // 6: DWELL=1, BLANK=0 instance, then async reset mid-sweep
      sel = 1'b1;
      start_pulse(1);
      push_sweep(8'h00, 1, 0, 0);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b1);
      push_n(1, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(10, "t6_fast");
      start_pulse(1);
      push_sweep(8'h00, 1, 0, 0);
      check_cycles(3, "t6_pre_reset");
      exp_q.delete();
      #2;
      check_now(obs_t'({3'd3, 1'b1, 1'b1, 1'b0}), "t6_before_reset");
      rst6_n = 1'b0;
      #1;
      check_now(obs_t'(6'b0), "t6_async_reset");
      @(negedge clk);
      rst6_n = 1'b1;
      @(posedge clk);
      #1;
      push_n(2, 3'd0, 1'b0, 1'b0, 1'b0);
      check_cycles(2, "t6_after_reset");

      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL scoreboard_drain: got %0d leftover entries, exp 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
